// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between instruction fetch and the memory
// (LDR/STR) stage. The memory stage normally wins; a bounded streak counter
// guarantees that a waiting fetch is granted after at most MAX_DATA_STREAK
// consecutive memory-stage grants. Read data returns one cycle after grant
// with a single-cycle valid strobe routed to the requester that issued it.
//
// Handshake: a requester raises req with addr/we/wdata and holds them stable
// until it sees gnt=1 in the same cycle; a cycle with req=1 and gnt=1 is the
// transfer. Reads answer exactly one cycle later with rvalid=1 for one cycle
// (no back-pressure on the return path). Writes complete in the grant cycle.
// Dropping req before gnt withdraws the request and nothing is issued.
//
// MAX_DATA_STREAK must lie in 1..15 (the streak counter is 4 bits wide).

module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [15:0] mem_rdata,

    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,

    // Observability of internal state (inflight encoding: 0 NONE, 1 IF_RD,
    // 2 MEM_RD, 3 MEM_WR).
    output logic [1:0]  inflight,
    output logic [3:0]  streak
);

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } inflight_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    inflight_t  state;
    inflight_t  state_next;
    logic [3:0] streak_q;
    logic [3:0] streak_next;

    // Grant decision: memory stage first unless fetch has waited out its streak.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!reset) begin
            if (if_req && (!mem_req || (streak_q == STREAK_MAX))) begin
                if_gnt = 1'b1;
            end else if (mem_req) begin
                mem_gnt = 1'b1;
            end
        end
    end

    // RAM port mux: winner drives the port, idle port is held at zero.
    always_comb begin
        ram_addr  = 16'h0000;
        ram_we    = 1'b0;
        ram_wdata = 16'h0000;
        if (if_gnt) begin
            ram_addr = if_addr;
        end else if (mem_gnt) begin
            ram_addr  = mem_addr;
            ram_we    = mem_we;
            ram_wdata = mem_wdata;
        end
    end

    // Next inflight state: what is being issued this cycle.
    always_comb begin
        state_next = NONE;
        if (if_gnt) begin
            state_next = IF_RD;
        end else if (mem_gnt) begin
            state_next = mem_we ? MEM_WR : MEM_RD;
        end
    end

    // Streak of memory-stage grants taken while a fetch was waiting.
    always_comb begin
        streak_next = streak_q;
        if (if_gnt || !if_req) begin
            streak_next = 4'd0;
        end else if (mem_gnt && (streak_q != STREAK_MAX)) begin
            streak_next = streak_q + 4'd1;
        end
    end

    // State, streak and read-return strobes; reset drops any pending return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NONE;
            streak_q   <= 4'd0;
            if_rvalid  <= 1'b0;
            mem_rvalid <= 1'b0;
        end else begin
            state      <= state_next;
            streak_q   <= streak_next;
            if_rvalid  <= (state_next == IF_RD);
            mem_rvalid <= (state_next == MEM_RD);
        end
    end

    // The RAM answers both requesters on one bus; the valids select the owner.
    assign if_rdata  = ram_rdata;
    assign mem_rdata = ram_rdata;
    assign inflight  = state;
    assign streak    = streak_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a driver issues directed cycles and pushes the
// expected read returns into queues; a monitor pops them when the DUT raises
// an rvalid. A behavioural RAM returns addr^16'h5A5A for untouched words.

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [1:0]  inflight;
    logic [3:0]  streak;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] if_exp_q[$];
    int          if_due_q[$];
    logic [15:0] mem_exp_q[$];
    int          mem_due_q[$];

    logic [15:0] ram_model [0:65535];

    mem_port_arbiter #(.MAX_DATA_STREAK(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .inflight   (inflight),
        .streak     (streak)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous RAM
    initial begin
        for (int a = 0; a < 65536; a++) ram_model[a] = 16'(a) ^ 16'h5A5A;
        ram_model[16'h0010] = 16'hA5A5;
    end
    always @(posedge clk) begin
        ram_rdata <= ram_model[ram_addr];
        if (ram_we) ram_model[ram_addr] <= ram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One directed cycle: apply inputs, check grants/RAM drive, queue returns.
    task automatic step(input string tag,
                        input logic i_req, input logic [15:0] i_addr,
                        input logic m_req, input logic m_we,
                        input logic [15:0] m_addr, input logic [15:0] m_wdata,
                        input logic e_if, input logic e_mem,
                        input logic [15:0] e_data, input logic [3:0] e_streak);
        if_req    = i_req;
        if_addr   = i_addr;
        mem_req   = m_req;
        mem_we    = m_we;
        mem_addr  = m_addr;
        mem_wdata = m_wdata;
        @(negedge clk);
        check({tag, "/if_gnt"}, {31'b0, if_gnt}, {31'b0, e_if});
        check({tag, "/mem_gnt"}, {31'b0, mem_gnt}, {31'b0, e_mem});
        check({tag, "/streak"}, {28'b0, streak}, {28'b0, e_streak});
        if (e_if) begin
            check({tag, "/ram_addr"}, {16'b0, ram_addr}, {16'b0, i_addr});
            check({tag, "/ram_we"}, {31'b0, ram_we}, 32'd0);
            if_exp_q.push_back(e_data);
            if_due_q.push_back(cyc + 1);
        end else if (e_mem) begin
            check({tag, "/ram_addr"}, {16'b0, ram_addr}, {16'b0, m_addr});
            check({tag, "/ram_we"}, {31'b0, ram_we}, {31'b0, m_we});
            check({tag, "/ram_wdata"}, {16'b0, ram_wdata}, {16'b0, m_wdata});
            if (!m_we) begin
                mem_exp_q.push_back(e_data);
                mem_due_q.push_back(cyc + 1);
            end
        end else begin
            check({tag, "/ram_idle"}, {15'b0, ram_we, ram_addr}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [3:0] e_streak);
        step(tag, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, e_streak);
    endtask

    // Monitor: every cycle, an rvalid must match the queue head due now.
    always @(negedge clk) begin
        if (if_exp_q.size() > 0 && if_due_q[0] == cyc) begin
            check("if_rvalid", {31'b0, if_rvalid}, 32'd1);
            check("if_rdata", {16'b0, if_rdata}, {16'b0, if_exp_q[0]});
            void'(if_exp_q.pop_front());
            void'(if_due_q.pop_front());
        end else begin
            check("if_rvalid_idle", {31'b0, if_rvalid}, 32'd0);
        end
        if (mem_exp_q.size() > 0 && mem_due_q[0] == cyc) begin
            check("mem_rvalid", {31'b0, mem_rvalid}, 32'd1);
            check("mem_rdata", {16'b0, mem_rdata}, {16'b0, mem_exp_q[0]});
            void'(mem_exp_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            check("mem_rvalid_idle", {31'b0, mem_rvalid}, 32'd0);
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        reset     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 16'h0050;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 16'h0777;
        mem_wdata = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/if_gnt", {31'b0, if_gnt}, 32'd0);
        check("rst/mem_gnt", {31'b0, mem_gnt}, 32'd0);
        check("rst/ram_we", {31'b0, ram_we}, 32'd0);
        check("rst/ram_addr", {16'b0, ram_addr}, 32'd0);
        check("rst/ram_wdata", {16'b0, ram_wdata}, 32'd0);
        check("rst/inflight", {30'b0, inflight}, 32'd0);
        check("rst/streak", {28'b0, streak}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First cycle after reset: memory stage wins the tie
        step("post_rst", 1'b1, 16'h0050, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b1, 16'h5A1A, 4'd0);
        idle("idle1", 4'd1);

        // Fetch only
        step("fetch", 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'hA5A5, 4'd0);
        idle("idle2", 4'd0);

        // Store, then load it back
        step("str", 1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, 1'b1, 16'h0, 4'd0);
        idle("idle3", 4'd0);
        step("ldr", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 1'b1, 16'h1234, 4'd0);
        idle("idle4", 4'd0);

        // Continuous contention: mem,mem,mem,if,mem,mem,mem,if
        step("both0", 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 1'b1, 16'h5ADA, 4'd0);
        step("both1", 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0081, 16'h0, 1'b0, 1'b1, 16'h5ADB, 4'd1);
        step("both2", 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0082, 16'h0, 1'b0, 1'b1, 16'h5AD8, 4'd2);
        step("both3", 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0083, 16'h0, 1'b1, 1'b0, 16'h5B5A, 4'd3);
        step("both4", 1'b1, 16'h0101, 1'b1, 1'b0, 16'h0083, 16'h0, 1'b0, 1'b1, 16'h5AD9, 4'd0);
        step("both5", 1'b1, 16'h0101, 1'b1, 1'b0, 16'h0084, 16'h0, 1'b0, 1'b1, 16'h5ADE, 4'd1);
        step("both6", 1'b1, 16'h0101, 1'b1, 1'b0, 16'h0085, 16'h0, 1'b0, 1'b1, 16'h5ADF, 4'd2);
        step("both7", 1'b1, 16'h0101, 1'b1, 1'b0, 16'h0086, 16'h0, 1'b1, 1'b0, 16'h5B5B, 4'd3);
        idle("idle5", 4'd0);

        // Reset asserted while an LDR is pending
        step("kill_a", 1'b1, 16'h0500, 1'b1, 1'b1, 16'h0400, 16'hBEEF, 1'b0, 1'b1, 16'h0, 4'd0);
        if_req    = 1'b1;
        if_addr   = 16'h0500;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 16'h0020;
        mem_wdata = 16'h0;
        @(negedge clk);
        check("kill_b/mem_gnt", {31'b0, mem_gnt}, 32'd1);
        check("kill_b/streak", {28'b0, streak}, 32'd1);
        check("kill_b/inflight", {30'b0, inflight}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("kill/mem_gnt", {31'b0, mem_gnt}, 32'd0);
        check("kill/if_gnt", {31'b0, if_gnt}, 32'd0);
        check("kill/ram_addr", {16'b0, ram_addr}, 32'd0);
        check("kill/streak", {28'b0, streak}, 32'd0);
        check("kill/inflight", {30'b0, inflight}, 32'd0);
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        check("kill/mem_rvalid", {31'b0, mem_rvalid}, 32'd0);
        check("kill/inflight_hold", {30'b0, inflight}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle("idle6", 4'd0);

        // Fetch waiting while mem_req pulses 1,1,0,1,1
        step("pulse0", 1'b1, 16'h0300, 1'b1, 1'b0, 16'h0090, 16'h0, 1'b0, 1'b1, 16'h5ACA, 4'd0);
        step("pulse1", 1'b1, 16'h0300, 1'b1, 1'b0, 16'h0091, 16'h0, 1'b0, 1'b1, 16'h5ACB, 4'd1);
        step("pulse2", 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b0, 16'h595A, 4'd2);
        step("pulse3", 1'b1, 16'h0301, 1'b1, 1'b0, 16'h0092, 16'h0, 1'b0, 1'b1, 16'h5AC8, 4'd0);
        step("pulse4", 1'b1, 16'h0301, 1'b1, 1'b0, 16'h0093, 16'h0, 1'b0, 1'b1, 16'h5AC9, 4'd1);
        idle("idle7", 4'd2);
        idle("idle8", 4'd0);

        @(negedge clk);
        check("if_q_drained", if_exp_q.size(), 32'd0);
        check("mem_q_drained", mem_exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU's single-port data/instruction RAM between the instruction-fetch stage and the memory (LDR/STR) stage. Each cycle it grants the RAM port to at most one requester and drives the RAM address, write-enable and write-data from the winner. It returns read data with a one-cycle valid strobe routed to the requester that issued the read. The memory stage has priority, and a bounded-streak rule guarantees fetch forward progress. The block sits between the pipeline stages and the RAM, and its grants act as the pipeline stall signals.

## Interface
- MAX_DATA_STREAK, 3, max consecutive memory-stage grants while fetch waits; range 1..15
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch requests a read
- if_addr  in  16  fetch address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  16  fetched word
- mem_req  in  1  memory stage requests access
- mem_we  in  1  1 = STR write, 0 = LDR read
- mem_addr  in  16  data address
- mem_wdata  in  16  store data
- mem_gnt  out  1  memory stage granted this cycle (combinational)
- mem_rvalid  out  1  mem_rdata valid (registered; reads only)
- mem_rdata  out  16  loaded word
- ram_addr  out  16  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data, valid one cycle after ram_addr is presented with ram_we=0

## Operation
- Inflight state register (`inflight`): NONE, IF_RD, MEM_RD, MEM_WR. It records what was issued last cycle. Next state: IF_RD if if_gnt; MEM_RD if mem_gnt&&!mem_we; MEM_WR if mem_gnt&&mem_we; else NONE.
- Grant rules, evaluated combinationally and forced to 0 while reset=1:
  - Only one requester active: that requester is granted.
  - Both active: fetch wins iff streak==MAX_DATA_STREAK; otherwise the memory stage wins.
  - Neither active: no grant.
- Streak counter, 4 bits:
  - Cleared on if_gnt or when if_req=0.
  - Incremented, saturating at MAX_DATA_STREAK, on mem_gnt while if_req=1.
- RAM drive:
  - Fetch wins: ram_addr=if_addr, ram_we=0.
  - Memory stage wins: ram_addr=mem_addr, ram_we=mem_we, ram_wdata=mem_wdata.
  - No grant: ram_addr=0, ram_we=0, ram_wdata=0.
- Read return:
  - if_rvalid<=1 iff next inflight=IF_RD.
  - mem_rvalid<=1 iff next inflight=MEM_RD.
  - if_rdata and mem_rdata both equal ram_rdata and are meaningful only when qualified by their valid.
- Writes complete in the grant cycle and produce no rvalid.
- Requester contract: while req=1 and gnt=0, the requester holds addr/we/wdata stable. A requester may drop req without a grant; nothing is issued for it.

## Timing
- Reset values: inflight=NONE, streak=0, if_rvalid=0, mem_rvalid=0. While reset is asserted: if_gnt=0, mem_gnt=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Reset is asynchronous. Assertion mid-read kills the pending rvalid immediately, and the read is not replayed.
- Grant is same-cycle (0 latency). Read data arrives 1 cycle after grant, with rvalid high for exactly 1 cycle per granted read.
- Full throughput: one grant every cycle, so back-to-back reads produce back-to-back rvalids.
- Fetch worst-case wait under continuous mem_req is MAX_DATA_STREAK cycles. It is granted on cycle MAX_DATA_STREAK+1.
- If mem_req=1 and if_req toggles, the streak clears on every cycle with if_req=0.
- Simultaneous rvalid and a new grant are legal: the registered return and the combinational issue are independent.

## Test plan
- Reset with if_req=1 and mem_req=1 held: both gnts=0, ram_we=0, both rvalids=0. After release, mem_gnt=1 in the first cycle.
- Fetch only, addr 0x0010 with RAM returning 0xA5A5: if_gnt=1 the same cycle, then next cycle if_rvalid=1, if_rdata=0xA5A5, mem_rvalid=0.
- STR to 0x0200 with wdata 0x1234: mem_gnt=1, ram_we=1, ram_addr=0x0200, ram_wdata=0x1234. The following cycle has no rvalid, and a subsequent LDR of 0x0200 yields mem_rvalid=1, mem_rdata=0x1234.
- Both requesting continuously, MAX_DATA_STREAK=3: grant sequence is mem,mem,mem,if,mem,mem,mem,if. if_rvalid is high exactly one cycle after each fetch grant.
- LDR granted, then reset asserted asynchronously before the next clock edge: mem_rvalid stays 0, streak=0, inflight=NONE.
- Fetch waiting while mem_req pulses high 2 cycles, low 1, high 2 with if_req held: the fetch is granted in the cycle mem_req is low. The streak never reaches 3.
